// File: rtl/vga_pixel_fetch_pkg.sv
// Shared definitions for the VGA pixel fetch block: default frame geometry,
// bit positions of the colour channels inside a 3-bit pixel, and the fetch
// FSM state type.
package vga_pixel_fetch_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    // Position of each channel inside a 3-bit {R,G,B} pixel field.
    localparam int unsigned RGB_R = 2;
    localparam int unsigned RGB_G = 1;
    localparam int unsigned RGB_B = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vga_pixel_fetch_fifo.sv
// vga_word_fifo: synchronous prefetch FIFO for frame-buffer words.
// Ports:
//   clk, reset (async, active-low)
//   push/wdata  write one word (ignored when full)
//   pop         drop the head word (ignored when empty)
//   flush       empty the FIFO; wins over push/pop in the same cycle
//   rdata       head word (first-word fall-through)
//   empty/count occupancy status
// DEPTH must be a power of 2 so the pointers wrap naturally.
module vga_word_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH)) && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams a 1-bit-per-channel frame buffer from word-wide
// memory to vga_controller, one {R,G,B} pixel per pix_req.
// Ports:
//   clk, reset (async, active-low)
//   frame_start  pulse: restart the frame at word 0
//   pix_req      consume one pixel this cycle
//   mem_rd       read strobe; mem_addr valid while high
//   mem_rdata    read data, RD_LAT cycles after mem_rd
//   pix_rgb      registered pixel for the most recent pix_req
//   underflow    sticky: a pix_req found no pixel available
//   frame_done   pulse after the last pixel of the frame is consumed
// Pixel p of a word sits in bits [3p+2:3p]; pixel 0 is shown first.
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned WORD_PIX   = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pix_req,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [3*WORD_PIX-1:0] mem_rdata,
    output logic [2:0]            pix_rgb,
    output logic                  underflow,
    output logic                  frame_done
);

    localparam int unsigned WORD_W    = 3 * WORD_PIX;
    localparam int unsigned NUM_PIX   = H_ACTIVE * V_ACTIVE;
    localparam int unsigned NUM_WORDS = NUM_PIX / WORD_PIX;
    localparam int unsigned PIX_W     = $clog2(NUM_PIX);
    localparam int unsigned IDX_W     = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W     = CNT_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIX - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_PIX - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              issued_all_q, issued_all_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic [WORD_W-1:0] sh_word_q, sh_word_d;
    logic [IDX_W-1:0]  sh_idx_q, sh_idx_d;
    logic              sh_valid_q, sh_valid_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [2:0]        pix_rgb_q, pix_rgb_d;
    logic              underflow_q, underflow_d;
    logic              frame_done_q, frame_done_d;

    logic              fifo_push, fifo_pop, fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occ;
    logic              room, rd_valid, active;
    logic [WORD_W-1:0] emit_word;
    logic [IDX_W-1:0]  emit_idx;

    function automatic logic [2:0] pixel_at(input logic [WORD_W-1:0] w,
                                            input logic [IDX_W-1:0]  i);
        logic [WORD_W-1:0] s;
        s = w >> (3 * i);
        return {s[RGB_R], s[RGB_G], s[RGB_B]};
    endfunction

    // Each bit of the valid pipe tracks one outstanding read by age; clearing
    // it on frame_start drops stale returns without a separate discard count.
    assign rd_valid  = vpipe_q[RD_LAT-1];
    assign fifo_push = rd_valid && !frame_start;
    assign occ       = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign room      = (occ < OCC_W'(FIFO_DEPTH));
    assign active    = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;

    vga_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (mem_rdata),
        .pop   (fifo_pop),
        .flush (frame_start),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issued_all_d = issued_all_q;
        inflight_d   = inflight_q;
        vpipe_d      = vpipe_q << 1;
        vpipe_d[0]   = 1'b0;
        sh_word_d    = sh_word_q;
        sh_idx_d     = sh_idx_q;
        sh_valid_d   = sh_valid_q;
        pix_cnt_d    = pix_cnt_q;
        pix_rgb_d    = pix_rgb_q;
        underflow_d  = underflow_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        mem_rd       = 1'b0;
        emit_word    = sh_word_q;
        emit_idx     = sh_idx_q;

        if (frame_start) begin
            // Restart overrides everything else this cycle, including any
            // pixel consumption and a frame_done that would otherwise fire.
            state_d      = ST_FILL;
            addr_d       = '0;
            issued_all_d = 1'b0;
            inflight_d   = '0;
            vpipe_d      = '0;
            sh_valid_d   = 1'b0;
            sh_idx_d     = '0;
            pix_cnt_d    = '0;
            underflow_d  = 1'b0;
        end else begin
            mem_rd     = active && !issued_all_q && room;
            vpipe_d[0] = mem_rd;
            if (mem_rd) begin
                if (addr_q == LAST_ADDR) issued_all_d = 1'b1;
                else                     addr_d = addr_q + 1'b1;
            end
            case ({mem_rd, rd_valid})
                2'b10:   inflight_d = inflight_q + 1'b1;
                2'b01:   inflight_d = inflight_q - 1'b1;
                default: inflight_d = inflight_q;
            endcase

            if (state_q == ST_FILL && (!room || issued_all_q)) state_d = ST_RUN;

            if (pix_req) begin
                if (!active) begin
                    pix_rgb_d = '0;
                end else begin
                    if (sh_valid_q || !fifo_empty) begin
                        // An empty shifter loads the FIFO head and emits its
                        // pixel 0 in the same step.
                        if (!sh_valid_q) begin
                            fifo_pop  = 1'b1;
                            emit_word = fifo_rdata;
                            emit_idx  = '0;
                        end
                        pix_rgb_d = pixel_at(emit_word, emit_idx);
                        if (emit_idx == LAST_IDX) begin
                            if (sh_valid_q && !fifo_empty) begin
                                fifo_pop   = 1'b1;
                                sh_word_d  = fifo_rdata;
                                sh_idx_d   = '0;
                                sh_valid_d = 1'b1;
                            end else begin
                                sh_valid_d = 1'b0;
                            end
                        end else begin
                            sh_word_d  = emit_word;
                            sh_idx_d   = emit_idx + 1'b1;
                            sh_valid_d = 1'b1;
                        end
                    end else begin
                        pix_rgb_d   = '0;
                        underflow_d = 1'b1;
                    end
                    // Missed pixels still count so frame_done stays aligned.
                    if (pix_cnt_q == LAST_PIX) begin
                        pix_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issued_all_q <= 1'b0;
            inflight_q   <= '0;
            vpipe_q      <= '0;
            sh_word_q    <= '0;
            sh_idx_q     <= '0;
            sh_valid_q   <= 1'b0;
            pix_cnt_q    <= '0;
            pix_rgb_q    <= '0;
            underflow_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issued_all_q <= issued_all_d;
            inflight_q   <= inflight_d;
            vpipe_q      <= vpipe_d;
            sh_word_q    <= sh_word_d;
            sh_idx_q     <= sh_idx_d;
            sh_valid_q   <= sh_valid_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_rgb_q    <= pix_rgb_d;
            underflow_q  <= underflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_rgb    = pix_rgb_q;
    assign underflow  = underflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch on a reduced 64x48 frame
// (3072 pixels, 384 words) so full-frame runs stay short.
module tb_vga_pixel_fetch;
    import vga_pixel_fetch_pkg::*;

    localparam int unsigned H        = 64;
    localparam int unsigned V        = 48;
    localparam int unsigned WP       = 8;
    localparam int unsigned AW       = 16;
    localparam int          NPIX     = H * V;
    localparam int          NWORDS   = NPIX / WP;

    logic          clk;
    logic          reset;
    logic          frame_start;
    logic          pix_req;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rdata;
    logic [2:0]    pix_rgb;
    logic          underflow;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    logic [2:0] sb[$];
    int         rd_cyc[$];
    int         rd_addr_log[$];
    int         rd_count  = 0;
    int         last_addr = -1;
    int         exp_addr  = 0;
    int         fd_count  = 0;
    int         max_fifo  = 0;
    int         cyc       = 0;

    vga_pixel_fetch #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .WORD_PIX   (WP),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4),
        .RD_LAT     (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pix_rgb     (pix_rgb),
        .underflow   (underflow),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [23:0] word_of(input logic [15:0] k);
        logic [2:0] lo;
        lo = k[2:0];
        return {8{lo}} ^ {8'h00, k};
    endfunction

    function automatic logic [2:0] exp_pix(input int n);
        logic [23:0] w;
        logic [23:0] s;
        w = word_of(16'(n / 8));
        s = w >> (3 * (n % 8));
        return s[2:0];
    endfunction

    // Memory model: one-cycle read latency.
    initial mem_rdata = '0;
    always @(posedge clk) if (mem_rd) mem_rdata <= word_of(mem_addr);

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset || frame_start) begin
            exp_addr = 0;
        end else if (mem_rd) begin
            check("rd_addr", 32'(mem_addr), 32'(exp_addr));
            exp_addr++;
            rd_count++;
            last_addr = int'(mem_addr);
            rd_cyc.push_back(cyc);
            rd_addr_log.push_back(int'(mem_addr));
        end
        if (frame_done) fd_count++;
        if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit req, input bit chk, input logic [2:0] exp);
        pix_req = req;
        if (req && chk) sb.push_back(exp);
        tick();
        if (req && chk) check("pix", 32'(pix_rgb), 32'(sb.pop_front()));
    endtask

    task automatic pulse_start();
        pix_req     = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        int  n;
        int  guard;
        int  fd0;
        bit  found;

        reset = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
        #25;
        check("rst_rgb", 32'(pix_rgb), 0);
        check("rst_uf", 32'(underflow), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_addr", 32'(mem_addr), 0);
        #30 reset = 1'b1;
        tick();

        // 1: idle, no frame_start
        rd_count = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 3'b000);
        pix_req = 1'b0;
        check("t1_uf", 32'(underflow), 0);
        check("t1_rd", 32'(rd_count), 0);

        // 2: initial fill
        rd_count = 0; rd_cyc.delete();
        pulse_start();
        repeat (10) tick();
        check("t2_rd_n", 32'(rd_count), 4);
        check("t2_last_addr", 32'(last_addr), 3);
        if (rd_cyc.size() >= 4)
            for (int i = 1; i < 4; i++) check("t2_rd_gap", 32'(rd_cyc[i] - rd_cyc[i-1]), 1);

        // 3: full frame, continuous requests
        fd_count = 0;
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, 1'b1, exp_pix(i));
            if (i == NPIX - 2) check("t3_fd_early", 32'(frame_done), 0);
            if (i == NPIX - 1) check("t3_fd", 32'(frame_done), 1);
        end
        pix_req = 1'b0;
        tick();
        check("t3_fd_pulse", 32'(frame_done), 0);
        repeat (5) tick();
        check("t3_fd_count", 32'(fd_count), 1);
        check("t3_uf", 32'(underflow), 0);
        check("t3_last_addr", 32'(last_addr), 32'(NWORDS - 1));
        check("t3_rd_total", 32'(rd_count), 32'(NWORDS));

        // 4: requests from the first cycle after frame_start
        pulse_start();
        step(1'b1, 1'b0, 3'b000);
        check("t4_first_rgb", 32'(pix_rgb), 0);
        check("t4_uf", 32'(underflow), 1);
        for (int i = 1; i < NPIX; i++) begin
            step(1'b1, 1'b0, 3'b000);
            if (i == NPIX - 1) check("t4_fd", 32'(frame_done), 1);
        end
        pix_req = 1'b0;
        repeat (5) tick();
        check("t4_uf_sticky", 32'(underflow), 1);
        pulse_start();
        check("t4_uf_clr", 32'(underflow), 0);

        // 5: restart with a read in flight
        repeat (10) tick();
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, exp_pix(n));
            n++;
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_rd) found = 1'b1;
            step(1'b1, 1'b1, exp_pix(n));
            n++;
        end
        check("t5_inflight", 32'(found), 1);
        rd_addr_log.delete();
        pulse_start();
        repeat (10) tick();
        check("t5_rd_seen", 32'(rd_addr_log.size() > 0), 1);
        if (rd_addr_log.size() > 0) check("t5_first_addr", 32'(rd_addr_log[0]), 0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, exp_pix(i));
        check("t5_uf", 32'(underflow), 0);

        // 6: random request gaps over a full frame
        pulse_start();
        repeat (10) tick();
        max_fifo = 0;
        fd0 = fd_count;
        n = 0; guard = 0;
        while (n < NPIX && guard < 20 * NPIX) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, 1'b1, exp_pix(n));
                n++;
            end else begin
                step(1'b0, 1'b0, 3'b000);
            end
            guard++;
        end
        pix_req = 1'b0;
        repeat (3) tick();
        check("t6_done_all", 32'(n), 32'(NPIX));
        check("t6_uf", 32'(underflow), 0);
        check("t6_fifo_le4", 32'(max_fifo <= 4), 1);
        check("t6_fd", 32'(fd_count - fd0), 1);

        // 7: reset mid-RUN
        pulse_start();
        step(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 3'b000);
        pix_req = 1'b0;
        check("t7_pre_uf", 32'(underflow), 1);
        #5 reset = 1'b0;
        #1;
        check("t7_rgb", 32'(pix_rgb), 0);
        check("t7_uf", 32'(underflow), 0);
        check("t7_fd", 32'(frame_done), 0);
        check("t7_rd", 32'(mem_rd), 0);
        check("t7_addr", 32'(mem_addr), 0);
        check("t7_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick();
        reset = 1'b1;
        rd_count = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 3'b000);
        pix_req = 1'b0;
        tick();
        check("t7_post_uf", 32'(underflow), 0);
        check("t7_post_rd", 32'(rd_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
